// File: rtl/uart_tx_arbiter.sv
// Shares the uart TX register port between NUM_REQ byte-stream requesters: programs BAUD/CTRL
// after reset, then grants round-robin with packet locking, writes TXDATA and polls STATUS bit0.
module uart_tx_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] BAUD_DIV  = 32'h1B8,
  parameter logic [31:0] CTRL_INIT = 32'h1,
  parameter logic [31:0] UART_BASE = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 init_done_o,
  output logic                 busy_o,
  output logic                 uart_req_o,
  output logic                 uart_we_o,
  output logic [31:0]          uart_addr_o,
  output logic [31:0]          uart_data_o,
  input  logic [31:0]          uart_data_i,
  input  logic                 uart_ack_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_BAUD   = 32'h8;
  localparam logic [31:0] OFF_TXDATA = 32'hC;

  typedef enum logic [2:0] {
    S_INIT_BAUD,
    S_INIT_CTRL,
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_POLL
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic             lock;
  logic             tx_last;

  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [7:0]       pick_byte;
  logic             unused_bits;

  // Only STATUS bit0 (tx busy) matters to this sequencer.
  assign unused_bits = ^uart_data_i[31:1];

  // Round-robin search starting just after the last owner; a held lock narrows it to that owner.
  always_comb begin : arb
    int k;
    k        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_vld && req_valid_i[k] && (!lock || (k == int'(rr_ptr)))) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(k);
      end
    end
  end

  assign pick_byte   = req_data_i[int'(pick_idx)*8 +: 8];
  assign busy_o      = (state != S_IDLE);
  assign req_ready_o = (rst && (state == S_WRITE) && uart_ack_i) ? grant_o : '0;

  // Latched packet-end flag of the byte in flight; no reset needed, only read after a grant.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && pick_vld) begin
      tx_last <= req_last_i[pick_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_INIT_BAUD;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      owner       <= '0;
      lock        <= 1'b0;
      grant_o     <= '0;
      init_done_o <= 1'b0;
      uart_req_o  <= 1'b1;
      uart_we_o   <= 1'b1;
      uart_addr_o <= UART_BASE + OFF_BAUD;
      uart_data_o <= BAUD_DIV;
    end else begin
      case (state)
        S_INIT_BAUD: begin
          if (uart_ack_i) begin
            state       <= S_INIT_CTRL;
            uart_addr_o <= UART_BASE + OFF_CTRL;
            uart_data_o <= CTRL_INIT;
          end
        end
        S_INIT_CTRL: begin
          if (uart_ack_i) begin
            state       <= S_IDLE;
            init_done_o <= 1'b1;
            uart_req_o  <= 1'b0;
            uart_we_o   <= 1'b0;
            uart_addr_o <= '0;
            uart_data_o <= '0;
          end
        end
        S_IDLE: begin
          if (pick_vld) begin
            state       <= S_WRITE;
            owner       <= pick_idx;
            grant_o     <= ONE_HOT0 << pick_idx;
            uart_req_o  <= 1'b1;
            uart_we_o   <= 1'b1;
            uart_addr_o <= UART_BASE + OFF_TXDATA;
            uart_data_o <= {24'h0, pick_byte};
          end
        end
        S_WRITE: begin
          if (uart_ack_i) begin
            state       <= S_GAP;
            rr_ptr      <= owner;
            lock        <= ~tx_last;
            uart_req_o  <= 1'b0;
            uart_we_o   <= 1'b0;
            uart_addr_o <= '0;
            uart_data_o <= '0;
          end
        end
        S_GAP: begin
          // Gives the uart one cycle to raise its busy flag before the first status read.
          state       <= S_POLL;
          uart_req_o  <= 1'b1;
          uart_we_o   <= 1'b0;
          uart_addr_o <= UART_BASE + OFF_STATUS;
        end
        S_POLL: begin
          if (uart_ack_i && !uart_data_i[0]) begin
            state       <= S_IDLE;
            uart_req_o  <= 1'b0;
            uart_addr_o <= '0;
            if (!lock) begin
              grant_o <= '0;
            end
          end
        end
        default: begin
          state       <= S_INIT_BAUD;
          lock        <= 1'b0;
          grant_o     <= '0;
          init_done_o <= 1'b0;
          uart_req_o  <= 1'b1;
          uart_we_o   <= 1'b1;
          uart_addr_o <= UART_BASE + OFF_BAUD;
          uart_data_o <= BAUD_DIV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester queues, a simple uart register model and a
// packet-level round-robin model predicting the order of TXDATA writes.
module tb_uart_tx_arbiter;

  localparam int N = 3;
  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_BAUD = 32'h8;
  localparam logic [31:0] A_TX   = 32'hC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [8*N-1:0] req_data_i;
  logic           init_done_o, busy_o, uart_req_o, uart_we_o, uart_ack_i;
  logic [31:0]    uart_addr_o, uart_data_o, uart_data_i;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .init_done_o(init_done_o), .busy_o(busy_o),
    .uart_req_o(uart_req_o), .uart_we_o(uart_we_o), .uart_addr_o(uart_addr_o),
    .uart_data_o(uart_data_o), .uart_data_i(uart_data_i), .uart_ack_i(uart_ack_i)
  );

  typedef struct { logic [7:0] b; logic l; } item_t;
  typedef struct { int r; logic [7:0] b; } exp_t;

  item_t       rq[N][$];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          mdl_p = N - 1;
  bit          mdl_lock = 1'b0;
  int          init_cnt = 0;
  int          ack_mode = 1;
  int          ack_pct = 100;
  int          busy_cnt = 0;
  int          frame_min = 1;
  int          frame_max = 8;
  logic [31:0] ctrl_reg = '0;
  bit          prev_stall = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected TXDATA order from the arbitration rules, assuming every queued byte is offered at once.
  task automatic build_expected();
    int   pos[N];
    int   w;
    bit   found;
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < N; k++) pos[k] = 0;
    while (1) begin
      found = 1'b0;
      w = 0;
      if (mdl_lock) begin
        w = mdl_p;
        found = (pos[w] < rq[w].size());
      end else begin
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (mdl_p + i) % N;
          if (!found && (pos[k] < rq[k].size())) begin
            w = k;
            found = 1'b1;
          end
        end
      end
      if (!found) break;
      e.r = w;
      e.b = rq[w][pos[w]].b;
      exp_q.push_back(e);
      mdl_lock = !rq[w][pos[w]].l;
      mdl_p = w;
      pos[w]++;
    end
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_item(input int k, input logic [7:0] b, input logic l);
    item_t it;
    it.b = b;
    it.l = l;
    rq[k].push_back(it);
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      #2;
      if ((exp_q.size() == 0) && queues_empty() && !busy_o) break;
    end
    chk({tag, "_remaining"}, 64'(exp_q.size()), 0);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_grant"}, 64'(grant_o), 0);
  endtask

  // Requesters, uart register model and bus monitor, all on the falling edge.
  always @(negedge clk) begin : mon
    bit   txw;
    exp_t e;
    if (busy_cnt > 0) busy_cnt--;
    for (int k = 0; k < N; k++) begin
      req_valid_i[k] = (rq[k].size() != 0);
      req_data_i[8*k +: 8] = (rq[k].size() != 0) ? rq[k][0].b : 8'h00;
      req_last_i[k] = (rq[k].size() != 0) ? rq[k][0].l : 1'b0;
    end
    case (ack_mode)
      0:       uart_ack_i = ($urandom_range(0, 99) < ack_pct);
      1:       uart_ack_i = 1'b1;
      default: uart_ack_i = 1'b0;
    endcase
    uart_data_i = {31'h0, (busy_cnt != 0)};
    #1;
    if (prev_stall) begin
      chk("hold_req", 64'(uart_req_o), 1);
      chk("hold_we", 64'(uart_we_o), 64'(prev_we));
      chk("hold_addr", 64'(uart_addr_o), 64'(prev_addr));
      chk("hold_data", 64'(uart_data_o), 64'(prev_data));
    end
    prev_stall = rst && uart_req_o && !uart_ack_i;
    prev_we    = uart_we_o;
    prev_addr  = uart_addr_o;
    prev_data  = uart_data_o;
    txw = 1'b0;
    if (rst && uart_req_o && uart_ack_i && uart_we_o) begin
      if (init_cnt == 0) begin
        chk("baud_addr", 64'(uart_addr_o), 64'(A_BAUD));
        chk("baud_data", 64'(uart_data_o), 64'h1B8);
        init_cnt = 1;
      end else if (init_cnt == 1) begin
        chk("ctrl_addr", 64'(uart_addr_o), 64'(A_CTRL));
        chk("ctrl_data", 64'(uart_data_o), 64'h1);
        ctrl_reg = uart_data_o;
        init_cnt = 2;
      end else begin
        chk("write_addr", 64'(uart_addr_o), 64'(A_TX));
        txw = 1'b1;
        chk("tx_init_done", 64'(init_done_o), 1);
        if (exp_q.size() == 0) begin
          chk("extra_byte", 64'(uart_data_o), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 64'(uart_data_o), {56'h0, e.b});
          chk("tx_grant", 64'(grant_o), 64'(1) << e.r);
          chk("tx_ready", 64'(req_ready_o), 64'(1) << e.r);
        end
        for (int k = 0; k < N; k++) if (req_ready_o[k] && (rq[k].size() != 0)) void'(rq[k].pop_front());
        if (ctrl_reg[0]) busy_cnt = $urandom_range(frame_min, frame_max) + 1;
      end
    end
    if (!txw && (req_ready_o != '0)) chk("stray_ready", 64'(req_ready_o), 0);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid_i = '0;
    req_last_i = '0;
    req_data_i = '0;
    uart_ack_i = 1'b0;
    uart_data_i = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_grant", 64'(grant_o), 0);
    chk("rst_init_done", 64'(init_done_o), 0);
    chk("rst_ready", 64'(req_ready_o), 0);
    chk("rst_bus_req", 64'(uart_req_o), 1);
    chk("rst_bus_addr", 64'(uart_addr_o), 64'(A_BAUD));

    // Init with ack tied high: BAUD at the first edge, CTRL and init_done at the second.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2 chk("init_done_c1", 64'(init_done_o), 0);
    @(negedge clk);
    #2 chk("init_done_c2", 64'(init_done_o), 1);
    chk("init_idle_busy", 64'(busy_o), 0);

    ack_mode = 0;
    ack_pct = 70;
    push_item(0, 8'h55, 1'b1);
    build_expected();
    wait_drain("single");

    // A three-byte packet from req1 must complete before req0 gets its byte.
    push_item(1, 8'hA1, 1'b0);
    push_item(1, 8'hA2, 1'b0);
    push_item(1, 8'hA3, 1'b1);
    push_item(0, 8'hB1, 1'b1);
    build_expected();
    wait_drain("locked");

    for (int r = 0; r < 8; r++) begin
      ack_pct = $urandom_range(20, 100);
      frame_max = $urandom_range(1, 10);
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int nb;
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) push_item(k, 8'($urandom), (b == nb - 1));
        end
      end
      build_expected();
      wait_drain("rand");
    end

    // Reset while polling a long frame: init is redone and the remaining bytes still go out.
    frame_min = 20;
    frame_max = 20;
    push_item(0, 8'hC0, 1'b1);
    push_item(1, 8'hC1, 1'b1);
    push_item(2, 8'hC2, 1'b1);
    build_expected();
    begin : find_poll
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 2000 && !seen; n++) begin
        @(negedge clk);
        #2;
        seen = uart_req_o && !uart_we_o && (uart_addr_o == A_STAT);
      end
      chk("poll_seen", 64'(seen), 1);
    end
    @(negedge clk);
    rst = 1'b0;
    init_cnt = 0;
    mdl_p = N - 1;
    mdl_lock = 1'b0;
    build_expected();
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst_grant", 64'(grant_o), 0);
    chk("midrst_init_done", 64'(init_done_o), 0);
    chk("midrst_bus_we", 64'(uart_we_o), 1);
    chk("midrst_bus_addr", 64'(uart_addr_o), 64'(A_BAUD));
    frame_min = 1;
    frame_max = 6;
    wait_drain("after_rst");
    chk("after_rst_init_done", 64'(init_done_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
